// File: rtl/hazard_stall_unit.sv
// ID/EX hazard unit: load-use bubbles, multi-cycle EX holds and flushes.
// Optional HAZARD_STALL_PERF_EN adds a bubble/hold cycle counter.
module hazard_stall_unit #(
   parameter int CTRL_W = 10,
   parameter int AW     = 5,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CTRL_W-1:0] ctrl_id,
   input  logic              id_memread,
   input  logic [AW-1:0]     id_rd,
   input  logic [AW-1:0]     id_rs1,
   input  logic [AW-1:0]     id_rs2,
   input  logic              id_uses_rs2,
   input  logic              mc_req,
   input  logic [CNT_W-1:0]  mc_len,
   input  logic              flush,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [AW-1:0]     ex_rd,
   output logic              ex_memread,
   output logic              ex_hold,
   output logic              pc_en,
   output logic              ifid_en,
   output logic              ifid_flush,
   output logic              bubble,
   output logic [1:0]        state,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [15:0]       bubble_count
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MC_STALL = 2'd1,
      RSV2     = 2'd2,
      RSV3     = 2'd3
   } st_t;

   st_t state_q;
   logic lu;
   logic mc_go;

   assign state = state_q;

   assign lu = ex_memread && (ex_rd != '0) &&
               ((ex_rd == id_rs1) ||
                (id_uses_rs2 && (ex_rd == id_rs2)));

   assign mc_go = mc_req && (mc_len >= CNT_W'(2));

   always_comb begin
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      ifid_flush = 1'b0;
      bubble     = 1'b0;
      ex_hold    = 1'b0;
      if (rst) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         ifid_flush = 1'b1;
         bubble     = 1'b1;
      end else if (flush) begin
         ifid_flush = 1'b1;
         bubble     = 1'b1;
      end else if (state_q == MC_STALL) begin
         pc_en   = 1'b0;
         ifid_en = 1'b0;
         ex_hold = 1'b1;
      end else if (lu) begin
         pc_en   = 1'b0;
         ifid_en = 1'b0;
         bubble  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         ex_ctrl    <= '0;
         ex_rd      <= '0;
         ex_memread <= 1'b0;
         stall_cnt  <= '0;
         state_q    <= RUN;
      end else if (state_q == MC_STALL) begin
         // EX registers keep the multi-cycle op until the count drains
         if (stall_cnt <= CNT_W'(1)) begin
            stall_cnt <= '0;
            state_q   <= RUN;
         end else begin
            stall_cnt <= stall_cnt - CNT_W'(1);
         end
      end else if (lu) begin
         ex_ctrl    <= '0;
         ex_rd      <= '0;
         ex_memread <= 1'b0;
         state_q    <= RUN;
      end else begin
         ex_ctrl    <= ctrl_id;
         ex_rd      <= id_rd;
         ex_memread <= id_memread;
         if (mc_go) begin
            state_q   <= MC_STALL;
            stall_cnt <= mc_len - CNT_W'(1);
         end else begin
            state_q <= RUN;
         end
      end
   end

`ifdef HAZARD_STALL_PERF_EN
   logic [15:0] bc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         bc_q <= '0;
      end else if ((bubble || ex_hold) && (bc_q != 16'hFFFF)) begin
         bc_q <= bc_q + 16'd1;
      end
   end

   assign bubble_count = bc_q;
`else
   assign bubble_count = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed table-driven bench for hazard_stall_unit plus multi-cycle
// corner sequences (stall drain, flush mid-stall, reset mid-stall).
module tb_hazard_stall_unit;

   logic       clk;
   logic       rst;
   logic [9:0] ctrl_id;
   logic       id_memread;
   logic [4:0] id_rd;
   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic       id_uses_rs2;
   logic       mc_req;
   logic [3:0] mc_len;
   logic       flush;
   logic [9:0] ex_ctrl;
   logic [4:0] ex_rd;
   logic       ex_memread;
   logic       ex_hold;
   logic       pc_en;
   logic       ifid_en;
   logic       ifid_flush;
   logic       bubble;
   logic [1:0] state;
   logic [3:0] stall_cnt;
   logic [15:0] bubble_count;

   int errors = 0;
   int checks = 0;

   hazard_stall_unit #(
      .CTRL_W(10),
      .AW(5),
      .CNT_W(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .ctrl_id(ctrl_id),
      .id_memread(id_memread),
      .id_rd(id_rd),
      .id_rs1(id_rs1),
      .id_rs2(id_rs2),
      .id_uses_rs2(id_uses_rs2),
      .mc_req(mc_req),
      .mc_len(mc_len),
      .flush(flush),
      .ex_ctrl(ex_ctrl),
      .ex_rd(ex_rd),
      .ex_memread(ex_memread),
      .ex_hold(ex_hold),
      .pc_en(pc_en),
      .ifid_en(ifid_en),
      .ifid_flush(ifid_flush),
      .bubble(bubble),
      .state(state),
      .stall_cnt(stall_cnt),
      .bubble_count(bubble_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       flush;
      logic [9:0] ctrl;
      logic       mr;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       uses;
      logic       mcq;
      logic [3:0] mcl;
      logic       e_pc;
      logic       e_if;
      logic       e_fl;
      logic       e_bub;
      logic       e_hold;
      logic [9:0] e_ctrl;
      logic [4:0] e_rd;
      logic       e_mr;
      logic [1:0] e_st;
      logic [3:0] e_cnt;
   } vec_t;

   vec_t vec [16];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic r, input logic f,
                         input logic [9:0] c, input logic m,
                         input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic u,
                         input logic q, input logic [3:0] l);
      rst = r;
      flush = f;
      ctrl_id = c;
      id_memread = m;
      id_rd = d;
      id_rs1 = s1;
      id_rs2 = s2;
      id_uses_rs2 = u;
      mc_req = q;
      mc_len = l;
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_comb(input string tag, input logic p,
                           input logic i, input logic fl,
                           input logic b, input logic h);
      chk({tag, ".pc_en"}, 32'(pc_en), 32'(p));
      chk({tag, ".ifid_en"}, 32'(ifid_en), 32'(i));
      chk({tag, ".ifid_flush"}, 32'(ifid_flush), 32'(fl));
      chk({tag, ".bubble"}, 32'(bubble), 32'(b));
      chk({tag, ".ex_hold"}, 32'(ex_hold), 32'(h));
   endtask

   task automatic chk_reg(input string tag, input logic [9:0] c,
                          input logic [4:0] d, input logic m,
                          input logic [1:0] s, input logic [3:0] n);
      chk({tag, ".ex_ctrl"}, 32'(ex_ctrl), 32'(c));
      chk({tag, ".ex_rd"}, 32'(ex_rd), 32'(d));
      chk({tag, ".ex_memread"}, 32'(ex_memread), 32'(m));
      chk({tag, ".state"}, 32'(state), 32'(s));
      chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(n));
   endtask

   initial begin
      int n;
      // rst flush ctrl mr rd rs1 rs2 uses mcq mcl | pc if fl bub hold | ctrl rd mr st cnt
      vec[0]  = '{1,0,10'h000,0, 0, 0, 0,0,0,0, 0,0,1,1,0, 10'h000, 0,0,0,0};
      vec[1]  = '{0,0,10'h1A5,1, 5, 1, 2,1,0,0, 1,1,0,0,0, 10'h1A5, 5,1,0,0};
      vec[2]  = '{0,0,10'h0F0,0, 6, 5, 2,1,0,0, 0,0,0,1,0, 10'h000, 0,0,0,0};
      vec[3]  = '{0,0,10'h0F0,0, 6, 5, 2,1,0,0, 1,1,0,0,0, 10'h0F0, 6,0,0,0};
      vec[4]  = '{0,0,10'h3FF,1, 0, 3, 4,1,0,0, 1,1,0,0,0, 10'h3FF, 0,1,0,0};
      vec[5]  = '{0,0,10'h011,0, 7, 0, 0,1,0,0, 1,1,0,0,0, 10'h011, 7,0,0,0};
      vec[6]  = '{0,0,10'h200,1, 9, 0, 1,0,0,0, 1,1,0,0,0, 10'h200, 9,1,0,0};
      vec[7]  = '{0,0,10'h055,1, 3, 1, 9,0,0,0, 1,1,0,0,0, 10'h055, 3,1,0,0};
      vec[8]  = '{0,0,10'h123,0, 4, 2, 3,1,1,4, 0,0,0,1,0, 10'h000, 0,0,0,0};
      vec[9]  = '{0,0,10'h0AA,0, 8, 2, 3,1,1,1, 1,1,0,0,0, 10'h0AA, 8,0,0,0};
      vec[10] = '{0,0,10'h0BB,0,10, 1, 1,0,1,0, 1,1,0,0,0, 10'h0BB,10,0,0,0};
      vec[11] = '{0,0,10'h1C1,1,12, 1, 1,0,0,0, 1,1,0,0,0, 10'h1C1,12,1,0,0};
      vec[12] = '{0,1,10'h3C3,1,13,12, 0,0,0,0, 1,1,1,1,0, 10'h000, 0,0,0,0};
      vec[13] = '{0,0,10'h2D2,0,11, 1, 1,0,1,2, 1,1,0,0,0, 10'h2D2,11,0,1,1};
      vec[14] = '{0,0,10'h000,0, 0, 0, 0,0,0,0, 0,0,0,0,1, 10'h2D2,11,0,0,0};
      vec[15] = '{0,0,10'h111,0, 1, 2, 3,1,0,0, 1,1,0,0,0, 10'h111, 1,0,0,0};

      set_in(1,0,0,0,0,0,0,0,0,0);
      tick;

      for (int i = 0; i < 16; i++) begin
         set_in(vec[i].rst, vec[i].flush, vec[i].ctrl, vec[i].mr,
                vec[i].rd, vec[i].rs1, vec[i].rs2, vec[i].uses,
                vec[i].mcq, vec[i].mcl);
         chk_comb($sformatf("v%0d", i), vec[i].e_pc, vec[i].e_if,
                  vec[i].e_fl, vec[i].e_bub, vec[i].e_hold);
         tick;
         chk_reg($sformatf("v%0d", i), vec[i].e_ctrl, vec[i].e_rd,
                 vec[i].e_mr, vec[i].e_st, vec[i].e_cnt);
      end

      // multi-cycle drain, len 4; a load-use pattern during the hold is ignored
      set_in(0,0,10'h155,1,5,0,0,0,1,4);
      tick;
      for (int k = 0; k < 3; k++) begin
         set_in(0,0,10'h000,0,0,5,5,1,0,0);
         chk_reg($sformatf("mc%0d", k), 10'h155, 5, 1, 1, 4'(3 - k));
         chk_comb($sformatf("mc%0d", k), 0, 0, 0, 0, 1);
         tick;
      end
      set_in(0,0,10'h000,0,0,1,2,1,0,0);
      chk_reg("mc_end", 10'h155, 5, 1, 0, 0);
      chk_comb("mc_end", 1, 1, 0, 0, 0);
      tick;

      // flush while stall_cnt is 2
      set_in(0,0,10'h2AA,0,7,0,0,0,1,4);
      tick;
      set_in(0,0,10'h000,0,0,0,0,0,0,0);
      tick;
      chk("fl.stall_cnt_before", 32'(stall_cnt), 32'd2);
      set_in(0,1,10'h000,0,0,0,0,0,0,0);
      chk_comb("fl", 1, 1, 1, 1, 0);
      tick;
      set_in(0,0,10'h000,0,0,0,0,0,0,0);
      chk_reg("fl", 10'h000, 0, 0, 0, 0);

      // reset while stall_cnt is 3
      set_in(0,0,10'h3AB,1,9,0,0,0,1,4);
      tick;
      chk("rs.stall_cnt_before", 32'(stall_cnt), 32'd3);
      set_in(1,0,10'h000,0,0,0,0,0,0,0);
      chk_comb("rs", 0, 0, 1, 1, 0);
      tick;
      set_in(0,0,10'h000,0,0,0,0,0,0,0);
      chk_reg("rs", 10'h000, 0, 0, 0, 0);
      chk("rs.bubble_count", 32'(bubble_count), 32'd0);

`ifdef HAZARD_STALL_PERF_EN
      set_in(0,1,10'h000,0,0,0,0,0,0,0);
      tick;
      set_in(0,0,10'h000,0,0,0,0,0,0,0);
      chk("perf.one_bubble", 32'(bubble_count), 32'd1);
`endif

      // longest length: 14 stall cycles, bounded wait
      set_in(0,0,10'h0CC,0,2,0,0,0,1,15);
      tick;
      set_in(0,0,10'h000,0,0,0,0,0,0,0);
      chk("max.stall_cnt", 32'(stall_cnt), 32'd14);
      n = 0;
      while (state == 2'd1 && n < 20) begin
         tick;
         n++;
      end
      chk("max.stall_cycles", 32'(n), 32'd14);
      chk("max.state", 32'(state), 32'd0);

`ifndef HAZARD_STALL_PERF_EN
      chk("tie.bubble_count", 32'(bubble_count), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
